// File: rtl/regfile32_dump.sv
// regfile32_dump: 32 x WIDTH MIPS general-purpose register file with a
// valid/ready dump engine that streams every register, in index order, to a
// debug/trace consumer.
//
// Ports:
//   clk, reset            single clock; asynchronous active-high reset
//   we, waddr, wdata      write port, committed on the falling clock edge
//   raddr_a/rdata_a       combinational read port A
//   raddr_b/rdata_b       combinational read port B
//   dump_start            request a full dump (sampled at rising edge, IDLE only)
//   dump_valid/dump_ready beat handshake; dump_idx/dump_data describe the beat
//   dump_busy             dump in progress (same as dump_valid)
//   dump_done             one-cycle pulse after the final beat is accepted
module regfile32_dump #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NREGS = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [4:0]       waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [4:0]       raddr_a,
  output logic [WIDTH-1:0] rdata_a,
  input  logic [4:0]       raddr_b,
  output logic [WIDTH-1:0] rdata_b,
  input  logic             dump_start,
  output logic             dump_valid,
  input  logic             dump_ready,
  output logic [4:0]       dump_idx,
  output logic [WIDTH-1:0] dump_data,
  output logic             dump_busy,
  output logic             dump_done
);

  localparam int unsigned AW = 5;
  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_e;

  // ---------------------------------------------------------------------------
  // Register storage (falling-edge writes)
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] regs_d [NREGS];

  // Register zero is never written, so it keeps its reset value of zero.
  always_comb begin
    regs_d = regs_q;
    if (we && (waddr != '0) && (32'(waddr) < NREGS)) begin
      regs_d[waddr] = wdata;
    end
  end

  // Falling-edge commit gives same-cycle write-back to decode forwarding.
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      regs_q <= '{default: '0};
    end else begin
      regs_q <= regs_d;
    end
  end

  // Combinational read ports; index zero and out-of-range indices read zero.
  always_comb begin
    rdata_a = '0;
    rdata_b = '0;
    if ((raddr_a != '0) && (32'(raddr_a) < NREGS)) begin
      rdata_a = regs_q[raddr_a];
    end
    if ((raddr_b != '0) && (32'(raddr_b) < NREGS)) begin
      rdata_b = regs_q[raddr_b];
    end
  end

  // ---------------------------------------------------------------------------
  // Dump engine (rising edge)
  // ---------------------------------------------------------------------------
  state_e           state_q;
  state_e           state_d;
  logic [AW-1:0]    ptr_q;
  logic [AW-1:0]    ptr_d;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;
  logic             valid_q;
  logic             valid_d;
  logic             done_q;
  logic             done_d;
  logic             beat_accept;
  logic             last_beat;
  logic [AW-1:0]    ptr_next;

  assign beat_accept = valid_q && dump_ready;
  assign last_beat   = (ptr_q == LAST_IDX);
  assign ptr_next    = ptr_q + AW'(1);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a start request while sending is ignored.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (dump_start) begin
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (beat_accept && last_beat) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output next-values. The data word is a snapshot taken when a beat is
  // loaded, so a stalled beat never changes even if its register is written.
  always_comb begin
    ptr_d   = ptr_q;
    data_d  = data_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (dump_start) begin
          ptr_d   = '0;
          data_d  = regs_q[0];
          valid_d = 1'b1;
        end
      end
      S_SEND: begin
        if (beat_accept) begin
          if (last_beat) begin
            ptr_d   = '0;
            valid_d = 1'b0;
            done_d  = 1'b1;
          end else begin
            ptr_d  = ptr_next;
            data_d = regs_q[ptr_next];
          end
        end
      end
      default: begin
        ptr_d   = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  // Output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign dump_valid = valid_q;
  assign dump_busy  = valid_q;
  assign dump_idx   = ptr_q;
  assign dump_data  = data_q;
  assign dump_done  = done_q;

endmodule

// File: tb/tb_regfile32_dump.sv
// Self-checking bench for regfile32_dump: a driver issues writes, reads and
// dumps against an array model; a negedge monitor pops expected beats from a
// scoreboard queue and also checks done timing and stall stability.
module tb_regfile32_dump;

  logic        clk = 1'b0;
  logic        reset;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  raddr_a;
  logic [31:0] rdata_a;
  logic [4:0]  raddr_b;
  logic [31:0] rdata_b;
  logic        dump_start;
  logic        dump_valid;
  logic        dump_ready;
  logic [4:0]  dump_idx;
  logic [31:0] dump_data;
  logic        dump_busy;
  logic        dump_done;

  regfile32_dump #(.WIDTH(32), .NREGS(32)) dut (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr_a(raddr_a), .rdata_a(rdata_a), .raddr_b(raddr_b), .rdata_b(rdata_b),
    .dump_start(dump_start), .dump_valid(dump_valid), .dump_ready(dump_ready),
    .dump_idx(dump_idx), .dump_data(dump_data), .dump_busy(dump_busy),
    .dump_done(dump_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  idx;
    logic [31:0] data;
  } beat_t;

  beat_t       sb[$];
  logic [31:0] model [32];
  int          total = 0;
  int          bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // A dump reports every register in index order, as the model holds them now.
  task automatic push_dump();
    beat_t b;
    for (int i = 0; i < 32; i++) begin
      b.idx  = 5'(i);
      b.data = model[i];
      sb.push_back(b);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  logic        prev_last = 1'b0;
  logic        prev_stall = 1'b0;
  logic [4:0]  prev_idx = '0;
  logic [31:0] prev_data = '0;

  always @(negedge clk) begin
    beat_t e;
    if (reset) begin
      prev_last  <= 1'b0;
      prev_stall <= 1'b0;
    end else begin
      chk("busy_eq_valid", 32'(dump_busy), 32'(dump_valid));
      chk("done_pulse", 32'(dump_done), 32'(prev_last));
      if (prev_last) chk("valid_in_done_cycle", 32'(dump_valid), 32'd0);
      if (prev_stall) begin
        chk("stall_idx_hold", 32'(dump_idx), 32'(prev_idx));
        chk("stall_data_hold", dump_data, prev_data);
      end
      if (dump_valid && dump_ready) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_beat: got idx %0d, none expected", dump_idx);
        end else begin
          e = sb.pop_front();
          chk("beat_idx", 32'(dump_idx), 32'(e.idx));
          chk("beat_data", dump_data, e.data);
        end
      end
      prev_last  <= dump_valid && dump_ready && (dump_idx == 5'd31);
      prev_stall <= dump_valid && !dump_ready;
      prev_idx   <= dump_idx;
      prev_data  <= dump_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    @(posedge clk);
    #1;
    we = 1'b1;
    waddr = a;
    wdata = d;
    raddr_a = a;
    @(negedge clk);
    #1;
    we = 1'b0;
    if (a != 5'd0) model[a] = d;
    // still before the next rising edge
    chk("wr_readback", rdata_a, model[a]);
  endtask

  // Asynchronous reset; leaves dump_start armed for the first edge after release.
  task automatic do_reset();
    we = 1'b0;
    dump_start = 1'b0;
    reset = 1'b1;
    #1;
    chk("rst_valid", 32'(dump_valid), 32'd0);
    chk("rst_idx", 32'(dump_idx), 32'd0);
    chk("rst_data", dump_data, 32'd0);
    chk("rst_done", 32'(dump_done), 32'd0);
    sb.delete();
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
    for (int i = 0; i < 32; i++) begin
      raddr_a = 5'(i);
      raddr_b = 5'(31 - i);
      #1;
      chk("rst_rdata_a", rdata_a, model[i]);
      chk("rst_rdata_b", rdata_b, model[31 - i]);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    dump_start = 1'b1;
    push_dump();
  endtask

  task automatic run_dump(input int stall_idx, input int stall_len, input int reset_idx,
                          input bit rnd, input bit chain_next, input bit prestarted,
                          input int exp_len);
    int cyc = 0;
    int stalled = 0;
    bit ended = 1'b0;
    logic [4:0] a;
    if (!prestarted) begin
      @(posedge clk);
      #1;
      dump_start = 1'b1;
      push_dump();
    end
    @(posedge clk);  // start sampled here
    #1;
    dump_start = 1'b0;
    chk("start_valid", 32'(dump_valid), 32'd1);
    chk("start_idx", 32'(dump_idx), 32'd0);
    chk("start_data0", dump_data, 32'd0);
    for (int k = 0; k < 400; k++) begin
      if (reset_idx >= 0 && dump_valid && dump_idx == 5'(reset_idx)) begin
        do_reset();
        return;
      end
      dump_ready = 1'b1;
      if (stall_idx >= 0 && dump_valid && dump_idx == 5'(stall_idx) && stalled < stall_len) begin
        dump_ready = 1'b0;
        if (stalled == 0) begin
          we = 1'b1;
          waddr = 5'(stall_idx);
          wdata = 32'hDEAD;
          model[stall_idx] = 32'hDEAD;
        end
        stalled++;
      end else if (rnd) begin
        dump_ready = ($urandom_range(3, 0) != 0);
        if (dump_valid && $urandom_range(2, 0) == 0) begin
          // only registers already captured by this dump
          a = 5'($urandom_range(32'(dump_idx), 0));
          we = 1'b1;
          waddr = a;
          wdata = $urandom;
          if (a != 5'd0) model[a] = wdata;
        end
        dump_start = 1'($urandom_range(1, 0));
        raddr_a = 5'($urandom);
        raddr_b = 5'($urandom);
      end
      @(negedge clk);
      #1;
      we = 1'b0;
      cyc++;
      if (rnd) begin
        chk("rnd_rdata_a", rdata_a, model[raddr_a]);
        chk("rnd_rdata_b", rdata_b, model[raddr_b]);
      end
      if (dump_done) begin
        ended = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    dump_ready = 1'b1;
    dump_start = chain_next;
    if (chain_next) push_dump();
    if (!ended) begin
      total++;
      bad++;
      $display("FAIL dump_timeout: no dump_done after %0d cycles", cyc);
    end else if (exp_len >= 0) begin
      chk("dump_len", 32'(cyc - 1), 32'(exp_len));
    end
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    reset = 1'b0;
    we = 1'b0;
    waddr = '0;
    wdata = '0;
    raddr_a = '0;
    raddr_b = '0;
    dump_start = 1'b0;
    dump_ready = 1'b1;
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
    #2;
    reset = 1'b1;
    #1;
    chk("init_valid", 32'(dump_valid), 32'd0);
    chk("init_idx", 32'(dump_idx), 32'd0);
    chk("init_data", dump_data, 32'd0);
    chk("init_done", 32'(dump_done), 32'd0);
    chk("init_rdata_a", rdata_a, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    for (int k = 1; k < 32; k++) wr(5'(k), 32'hA5A50000 + 32'(k));
    raddr_a = 5'd5;
    raddr_b = 5'd31;
    #1;
    chk("read_a5", rdata_a, 32'hA5A50005);
    chk("read_b31", rdata_b, 32'hA5A5001F);

    wr(5'd0, 32'hFFFFFFFF);
    chk("read_a0", rdata_a, 32'd0);
    wr(5'd7, 32'h1234);
    chk("fwd_a7", rdata_a, 32'h0000_1234);

    // full dump, back-to-back with a dump stalled at beat 9
    run_dump(-1, 0, -1, 1'b0, 1'b1, 1'b0, 32);
    run_dump(9, 3, -1, 1'b0, 1'b0, 1'b1, 35);
    raddr_a = 5'd9;
    #1;
    chk("reg9_after_stall", rdata_a, 32'hDEAD);

    repeat (20) wr(5'($urandom), $urandom);
    repeat (4) run_dump(-1, 0, -1, 1'b1, 1'b0, 1'b0, -1);

    // reset mid-dump, then the armed start restarts from beat 0
    run_dump(-1, 0, 12, 1'b0, 1'b0, 1'b0, -1);
    run_dump(-1, 0, -1, 1'b0, 1'b0, 1'b1, 32);

    repeat (3) @(posedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL sb_empty: %0d beats outstanding, want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile32_dump.md
# regfile32_dump

32 x 32-bit MIPS general-purpose register file with a sequential read-out (dump) engine. Writes land on the falling clock edge, so a value written in a cycle is readable before the next rising edge. Two combinational read ports feed the decode stage. A valid/ready dump engine streams all 32 registers, in index order, to a debug/trace consumer. The dump engine is the reader side of the write-enabled falling-edge register storage.

## Interface
Parameters:
- WIDTH, 32, data width of each register.
- NREGS, 32, number of registers; index width is fixed at 5 bits.

Ports:
- clk  in  1  single clock. Storage writes on negedge; dump engine on posedge.
- reset  in  1  asynchronous, active-high reset.
- we  in  1  write enable, sampled at negedge clk.
- waddr  in  5  write register index.
- wdata  in  WIDTH  write data.
- raddr_a  in  5  read port A index.
- rdata_a  out  WIDTH  read port A data (combinational).
- raddr_b  in  5  read port B index.
- rdata_b  out  WIDTH  read port B data (combinational).
- dump_start  in  1  request a full register dump; sampled at posedge.
- dump_valid  out  1  dump beat valid.
- dump_ready  in  1  consumer accepts the beat.
- dump_idx  out  5  index of the current beat.
- dump_data  out  WIDTH  captured contents of register dump_idx.
- dump_busy  out  1  dump in progress; equals dump_valid.
- dump_done  out  1  one-cycle pulse after the final beat is accepted.

## Operation
Storage:
- At negedge clk, when we=1 and waddr!=0, regs[waddr] <= wdata.
- Writes with waddr=0 are discarded. regs[0] always reads 0.
- rdata_a = regs[raddr_a] and rdata_b = regs[raddr_b], both purely combinational.

Dump FSM (posedge clk), states IDLE and SEND:
- IDLE: dump_valid=0. When dump_start=1, go to SEND with ptr=0 and dump_data <= regs[0] (always 0).
- SEND: dump_valid=1, dump_idx=ptr.
  - When dump_valid & dump_ready and ptr<31: ptr <= ptr+1 and dump_data <= regs[ptr+1].
  - When dump_valid & dump_ready and ptr=31: go to IDLE and pulse dump_done for one cycle.
- dump_data is a registered snapshot. It must not change while valid=1 and ready=0, even if the presented register is written meanwhile.
- dump_start is ignored while in SEND.
- dump_start=1 in the same cycle as the dump_done pulse starts a new dump immediately (IDLE to SEND on that posedge).
- No wrap: ptr never advances past 31.
- Reset (async, any time, including mid-dump):
  - all regs=0, state=IDLE, ptr=0;
  - dump_valid=0, dump_idx=0, dump_data=0, dump_done=0.
  - An interrupted dump is abandoned and never resumed.

## Timing
- Write-to-read: a write at the negedge in cycle N is visible on rdata_a/b before posedge N+1, which gives same-cycle WB-to-ID forwarding.
- The snapshot taken at posedge N+1 includes writes from the negedge in cycle N.
- dump_start high at posedge N: dump_valid=1 and dump_idx=0 from just after posedge N.
- With dump_ready held at 1 from that point:
  - one beat per cycle, 32 cycles total;
  - the last handshake is at posedge N+32;
  - dump_done=1 for the cycle after posedge N+32, and dump_valid=0 in that same cycle.
- Each cycle of ready=0 stalls the dump by exactly one cycle; idx and data hold.
- Reset assertion clears all outputs without waiting for a clock edge. The first dump_start is honoured at the first posedge after reset deasserts.

## Test plan
- Reset, then write regs[k]=32'hA5A50000+k for k=1..31, then read A=5, B=31 -> rdata_a=32'hA5A50005, rdata_b=32'hA5A5001F.
- Write waddr=0 with wdata=32'hFFFFFFFF, then read A=0 -> rdata_a=0. Dump beat 0 also carries 0.
- Write reg 7=32'h1234 at a negedge, then sample rdata_a (raddr_a=7) before the next posedge -> 32'h1234.
- dump_start with ready=1 throughout -> 32 beats with idx 0..31 in order and data equal to the loaded values. dump_done pulses once, one cycle after the idx=31 handshake.
- Drop ready at idx=9 for 3 cycles and write reg 9=32'hDEAD during the stall -> idx stays 9 and data stays the old value throughout. The beat is accepted after the stall, and total dump length is 35 cycles.
- Assert reset asynchronously mid-dump at idx=12 -> dump_valid=0, dump_idx=0 and dump_data=0 immediately, and all registers read 0. A new dump_start restarts from idx 0.
